// File: rtl/corefifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : corefifo_pkg
//  Description : Shared definitions for the COREFIFO pointer-crossing logic.
//                Holds the Gray encode/decode helpers and the pointer-width
//                convention.
//
//                A pointer is one bit wider than the RAM address. The extra
//                MSB separates "full" from "empty" when the address bits of
//                the write and read pointers are equal.
//
//                The helpers work on a fixed maximum width. Callers
//                zero-extend their pointer into ptr_t and truncate the
//                result back to their own width. Leading zeros encode and
//                decode to zeros, so this is exact for any width up to
//                MAX_PTR_W.
//  Revision    : 1.0  initial release
// ============================================================================
package corefifo_pkg;

  // Pointer width = address width + this many bits (the wrap bit).
  localparam int PTR_EXTRA_BITS = 1;

  localparam int MAX_PTR_W = 32;
  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // MSB-first decode: b[MSB] = g[MSB], then b[i-1] = b[i] ^ g[i-1].
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/corefifo_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module      : corefifo_ptr_sync
//  Description : Multi-flop synchronizer for a Gray-coded pointer that
//                crosses from the other clock domain. At most one bit of a
//                Gray pointer changes per step. A sample taken mid-transition
//                therefore resolves to either the old value or the new one.
//  Ports       : clk    in   destination-domain clock
//                reset  in   asynchronous active-high reset
//                d      in   [WIDTH-1:0] pointer from the source-domain flop
//                q      out  [WIDTH-1:0] synchronized pointer
//                             (SYNC_STAGES cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module corefifo_ptr_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/corefifo_wrptr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : corefifo_wrptr_gen
//  Description : Write-side pointer generator of the dual-clock COREFIFO.
//                - Keeps the binary write pointer and drives the RAM write
//                  address.
//                - Registers the Gray-coded pointer for the read domain.
//                - Synchronizes the read domain's Gray pointer.
//                - Derives full, almost_full, the fill count and overflow.
//  Ports       : clk          in   write-domain clock
//                reset        in   asynchronous active-high reset
//                we           in   write request
//                rd_gray_in   in   [ADDRWIDTH:0] read pointer, Gray coded
//                wr_addr      out  [ADDRWIDTH-1:0] RAM write address
//                wr_gray      out  [ADDRWIDTH:0] registered Gray write pointer
//                wr_en_ram    out  RAM write strobe (we && !full)
//                full         out  registered full flag
//                almost_full  out  registered wr_count >= AFULL_THRESH
//                wr_count     out  [ADDRWIDTH:0] registered occupancy
//                overflow     out  one-cycle pulse after a rejected write
//  Revision    : 1.0  initial release
// ============================================================================
module corefifo_wrptr_gen
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH    = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rd_gray_in,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [ADDRWIDTH:0]   wr_gray,
  output logic                 wr_en_ram,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDRWIDTH:0]   wr_count,
  output logic                 overflow
);

  localparam int PTR_W = ADDRWIDTH + PTR_EXTRA_BITS;

  // Full means the write pointer is exactly one lap ahead of the read
  // pointer. In reflected Gray code, adding 2^ADDRWIDTH flips the top two
  // bits and leaves the rest unchanged.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic             accept;
  logic [PTR_W-1:0] rd_gray_s;
  logic [PTR_W-1:0] rd_bin_s;

  logic [PTR_W-1:0] wr_bin_q,      wr_bin_d;
  logic [PTR_W-1:0] wr_gray_q,     wr_gray_d;
  logic [PTR_W-1:0] wr_count_q,    wr_count_d;
  logic             full_q,        full_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q,    overflow_d;

  corefifo_ptr_sync #(
    .WIDTH       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rd_gray_in),
    .q     (rd_gray_s)
  );

  // All flags are computed from the next pointer. A write accepted at an
  // edge is therefore already reflected in full, so a back-to-back write
  // at the next edge is correctly rejected.
  always_comb begin
    accept   = we && !full_q;
    wr_bin_d = wr_bin_q;
    if (accept) begin
      wr_bin_d = wr_bin_q + PTR_W'(1);
    end
    wr_gray_d     = PTR_W'(bin2gray(ptr_t'(wr_bin_d)));
    rd_bin_s      = PTR_W'(gray2bin(ptr_t'(rd_gray_s)));
    wr_count_d    = wr_bin_d - rd_bin_s;
    full_d        = (wr_gray_d == (rd_gray_s ^ FULL_MASK));
    almost_full_d = (wr_count_d >= AFULL_LVL);
    overflow_d    = we && full_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_addr     = wr_bin_q[ADDRWIDTH-1:0];
  assign wr_gray     = wr_gray_q;
  assign wr_en_ram   = accept;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_count    = wr_count_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_corefifo_wrptr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_corefifo_wrptr_gen
//  Description : Self-checking bench for corefifo_wrptr_gen
//                (ADDRWIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6).
//                An occupancy model based on pointer arithmetic is compared
//                against the DUT every cycle. Directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_corefifo_wrptr_gen;

  localparam int AW = 3;
  localparam int SS = 2;
  localparam int AF = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [3:0] rd_gray_in;
  logic [2:0] wr_addr;
  logic [3:0] wr_gray;
  logic       wr_en_ram;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_count;
  logic       overflow;

  corefifo_wrptr_gen #(
    .ADDRWIDTH    (AW),
    .SYNC_STAGES  (SS),
    .AFULL_THRESH (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .rd_gray_in  (rd_gray_in),
    .wr_addr     (wr_addr),
    .wr_gray     (wr_gray),
    .wr_en_ram   (wr_en_ram),
    .full        (full),
    .almost_full (almost_full),
    .wr_count    (wr_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int ungray(input int g);
    for (int b = 0; b < 16; b++) begin
      if (gray(b) == g) return b;
    end
    return 0;
  endfunction

  // ---------------- occupancy model ----------------
  int         m_wr = 0;
  int         m_count = 0;
  int         m_rd_seen = 0;
  bit         m_full = 1'b0;
  bit         m_af = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_acc;
  logic [3:0] m_hist [SS] = '{default: 4'd0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wr = 0; m_count = 0; m_full = 0; m_af = 0; m_ovf = 0;
      for (int i = 0; i < SS; i++) m_hist[i] = 4'd0;
    end else begin
      m_ovf = we && m_full;
      m_acc = we && !m_full;
      if (m_acc) m_wr = (m_wr + 1) % 16;
      // Read pointer the write domain sees now: the input from SS edges ago.
      m_rd_seen = ungray(int'(m_hist[SS-1]));
      for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = rd_gray_in;
      m_count = (m_wr - m_rd_seen + 16) % 16;
      m_full  = (m_count == 8);
      m_af    = (m_count >= AF);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    chk("cyc_wr_addr",   32'(wr_addr),     32'(m_wr % 8));
    chk("cyc_wr_gray",   32'(wr_gray),     32'(gray(m_wr)));
    chk("cyc_full",      32'(full),        32'(m_full));
    chk("cyc_afull",     32'(almost_full), 32'(m_af));
    chk("cyc_count",     32'(wr_count),    32'(m_count));
    chk("cyc_overflow",  32'(overflow),    32'(m_ovf));
    chk("cyc_wr_en_ram", 32'(wr_en_ram),   32'(we && !m_full));
  end

  task automatic cyc(input logic w);
    @(negedge clk);
    we = w;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    we = 1'b0;
    rd_gray_in = 4'd0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int  gray_exp [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
  bit  saw_full;
  bit  saw_ovf;

  initial begin
    reset = 1'b1;
    we = 1'b0;
    rd_gray_in = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1. Reset asserted mid-cycle with we=1
    cyc(1'b1);
    cyc(1'b1);
    chk("pre_reset_addr", 32'(wr_addr), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_wr_addr",  32'(wr_addr),     32'd0);
    chk("rst_wr_gray",  32'(wr_gray),     32'd0);
    chk("rst_full",     32'(full),        32'd0);
    chk("rst_afull",    32'(almost_full), 32'd0);
    chk("rst_count",    32'(wr_count),    32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    chk("rst_wr_en",    32'(wr_en_ram),   32'd1);
    @(posedge clk);
    #2;
    chk("rst_write_lost", 32'(wr_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("first_write_addr", 32'(wr_addr),   32'd0);
    chk("first_write_en",   32'(wr_en_ram), 32'd1);
    @(posedge clk);
    #2;
    chk("after_first_addr", 32'(wr_addr), 32'd1);
    chk("after_first_gray", 32'(wr_gray), 32'd1);

    // 2. Fill from empty
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1);
      chk("fill_gray",  32'(wr_gray),     32'(gray_exp[k]));
      chk("fill_afull", 32'(almost_full), 32'(k >= 5));
      chk("fill_full",  32'(full),        32'(k == 7));
    end
    chk("fill_count", 32'(wr_count), 32'd8);

    // 3. Overflow
    @(negedge clk);
    we = 1'b1;
    #1;
    chk("ovf_wr_en", 32'(wr_en_ram), 32'd0);
    @(posedge clk);
    #2;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_gray",  32'(wr_gray),  32'd12);
    chk("ovf_count", 32'(wr_count), 32'd8);
    chk("ovf_full",  32'(full),     32'd1);
    cyc(1'b0);
    chk("ovf_one_cycle", 32'(overflow), 32'd0);

    // 4. Read release: full falls exactly 3 edges later
    @(negedge clk);
    rd_gray_in = 4'b0001;
    @(posedge clk); #2;
    chk("rel_full_e1", 32'(full), 32'd1);
    @(posedge clk); #2;
    chk("rel_full_e2", 32'(full), 32'd1);
    @(posedge clk); #2;
    chk("rel_full_e3",  32'(full),        32'd0);
    chk("rel_count",    32'(wr_count),    32'd7);
    chk("rel_afull",    32'(almost_full), 32'd1);

    // 5. Write at the edge where the synchronized read pointer advances
    @(negedge clk);
    rd_gray_in = 4'b0011;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    we = 1'b1;
    #1;
    chk("sim_wr_en", 32'(wr_en_ram), 32'd1);
    @(posedge clk); #2;
    chk("sim_full",  32'(full),        32'd0);
    chk("sim_count", 32'(wr_count),    32'd7);
    chk("sim_gray",  32'(wr_gray),     32'd13);
    chk("sim_afull", 32'(almost_full), 32'd1);

    // 6. Wrap-around with the read pointer trailing by 2 cycles
    pulse_reset();
    saw_full = 1'b0;
    saw_ovf  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      we = 1'b1;
      rd_gray_in = 4'(gray((k >= 2) ? ((k - 2) % 16) : 0));
      @(posedge clk);
      #2;
      if (full) saw_full = 1'b1;
      if (overflow) saw_ovf = 1'b1;
      if (k + 1 == 15) chk("wrap_gray_15", 32'(wr_gray), 32'd8);
      if (k + 1 == 16) begin
        chk("wrap_gray_16", 32'(wr_gray), 32'd0);
        chk("wrap_addr_16", 32'(wr_addr), 32'd0);
      end
    end
    chk("wrap_no_full", 32'(saw_full), 32'd0);
    chk("wrap_no_ovf",  32'(saw_ovf),  32'd0);
    chk("wrap_gray_20", 32'(wr_gray),  32'd6);
    cyc(1'b0);
    cyc(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
